cache_fill_fsm: RTL and testbench

- Miss-service controller between the pipelined CPU's L1 caches (instruction and data) and the shared multi-cycle main memory.
- On a cache miss it fetches the whole 16-byte block (8 words) from memory with pipelined reads.
- It steers each returned word into the cache data array, then writes the tag.
- It holds fsm_busy so the pipeline stalls until the fill completes. One instance per cache.

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_counter.sv | 44 ++++
 rtl/cache_fill_fsm.sv | 99 +++++++++
 tb/tb_cache_fill_fsm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants for the L1 miss-service fill controller: state encoding,
// block geometry and the informational memory latency.
package cache_fill_fsm_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_OFF_W      = 3;
    localparam int ADDR_W          = 16;

    // The FSM counts returned words, never cycles, so this is documentation only.
    localparam int MEM_LATENCY     = 4;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Generic register cell plus the 3-bit word counter built on it; the fill
// controller uses one counter for issued reads and one for returned words.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        q_o <= d_i;
    end

endmodule

module fill_counter_3bit
    import cache_fill_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [WORD_OFF_W-1:0] cnt_o
);

    logic [WORD_OFF_W-1:0] cnt_d;

    // Clear wins over increment; the count wraps naturally from 7 to 0.
    always_comb begin
        cnt_d = cnt_o;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_o + 1'b1;
        end
    end

    dff #(.W(WORD_OFF_W)) u_cnt_reg (
        .clk (clk),
        .d_i (cnt_d),
        .q_o (cnt_o)
    );

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service controller: on a cache miss it issues pipelined reads for the
// whole block, steers returned words into the data array, then writes the tag.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data,
    output logic                  fsm_busy,
    output logic                  memory_read_en,
    output logic [ADDR_W-1:0]     memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [WORD_OFF_W-1:0] fill_word,
    output logic [ADDR_W-1:0]     fill_block,
    output logic [15:0]           fill_data
);

    localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(WORDS_PER_BLOCK - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_W-1:0]     fill_block_q, fill_block_d;
    logic [0:0]            issue_done_q, issue_done_d;
    logic [WORD_OFF_W-1:0] issue_cnt, ret_cnt;

    logic inFill, accept, issuing, retValid, lastRet, cntClr;

    assign inFill   = (state_q == ST_FILL);
    assign accept   = !inFill && miss_detected;
    assign issuing  = inFill && !issue_done_q[0];
    // Reset gates the array strobes so an aborted fill can never write a tag.
    assign retValid = inFill && memory_data_valid && !rst;
    assign lastRet  = retValid && (ret_cnt == LAST_WORD);
    assign cntClr   = rst || accept;

    fill_counter_3bit u_issue_cnt (
        .clk   (clk),
        .clr_i (cntClr),
        .inc_i (issuing),
        .cnt_o (issue_cnt)
    );

    fill_counter_3bit u_ret_cnt (
        .clk   (clk),
        .clr_i (cntClr),
        .inc_i (retValid),
        .cnt_o (ret_cnt)
    );

    // Issue counter wraps after the last read, so saturation is tracked separately.
    always_comb begin
        issue_done_d = issue_done_q;
        if (cntClr) begin
            issue_done_d = 1'b0;
        end else if (issuing && (issue_cnt == LAST_WORD)) begin
            issue_done_d = 1'b1;
        end
    end

    dff #(.W(1)) u_issue_done (
        .clk (clk),
        .d_i (issue_done_d),
        .q_o (issue_done_q)
    );

    always_comb begin
        state_d      = state_q;
        fill_block_d = fill_block_q;
        if (accept) begin
            state_d      = ST_FILL;
            fill_block_d = miss_address & BLOCK_MASK;
        end else if (lastRet) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_block_q <= '0;
        end else begin
            state_q      <= state_d;
            fill_block_q <= fill_block_d;
        end
    end

    assign fsm_busy         = inFill;
    assign memory_read_en   = issuing;
    assign memory_address   = issuing ? (fill_block_q + ADDR_W'({issue_cnt, 1'b0})) : '0;
    assign write_data_array = retValid;
    assign write_tag_array  = lastRet;
    assign fill_word        = retValid ? ret_cnt : '0;
    assign fill_block       = inFill ? fill_block_q : '0;
    assign fill_data        = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model
// stepped alongside the stimulus.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_block;
    logic [15:0] fill_data;

    logic        pipeV [4];
    logic [15:0] pipeA [4];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word         (fill_word),
        .fill_block        (fill_block),
        .fill_data         (fill_data)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; memory returns word (addr>>1)&7 as A000+index four cycles after the read.
    task automatic applyStimulus();
        logic        re;
        logic [15:0] ad;
        re = (memory_read_en === 1'b1);
        ad = memory_address;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pipeV[i] = pipeV[i-1];
            pipeA[i] = pipeA[i-1];
        end
        pipeV[0]          = re;
        pipeA[0]          = ad;
        memory_data_valid = pipeV[3];
        memory_data       = pipeV[3] ? (16'hA000 + {13'b0, pipeA[3][3:1]}) : 16'h0000;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
    endtask

    task automatic runFill(input logic [15:0] addrIn, input logic [15:0] base, input int pulseCyc);
        logic [15:0] expAddr, expFw, expFd, expBlk;
        logic        expRe, expWr, expTag, expBusy;
        miss_detected = 1'b1;
        miss_address  = addrIn;
        #2;
        for (int c = 1; c <= 13; c++) begin
            applyStimulus();
            if (c == pulseCyc) begin
                miss_detected = 1'b1;
                miss_address  = 16'h4000;
            end
            #2;
            expRe   = (c <= 8);
            expAddr = expRe ? base + 16'(2 * (c - 1)) : 16'h0000;
            expWr   = (c >= 5) && (c <= 12);
            expFw   = expWr ? 16'(c - 5) : 16'h0000;
            expFd   = expWr ? 16'hA000 + 16'(c - 5) : 16'h0000;
            expTag  = (c == 12);
            expBusy = (c <= 12);
            expBlk  = expBusy ? base : 16'h0000;
            checkOutput($sformatf("%h c%0d busy", base, c), 16'(fsm_busy), 16'(expBusy));
            checkOutput($sformatf("%h c%0d rd_en", base, c), 16'(memory_read_en), 16'(expRe));
            checkOutput($sformatf("%h c%0d rd_addr", base, c), memory_address, expAddr);
            checkOutput($sformatf("%h c%0d wr_data", base, c), 16'(write_data_array), 16'(expWr));
            checkOutput($sformatf("%h c%0d fill_word", base, c), 16'(fill_word), expFw);
            checkOutput($sformatf("%h c%0d fill_data", base, c), fill_data, expFd);
            checkOutput($sformatf("%h c%0d wr_tag", base, c), 16'(write_tag_array), 16'(expTag));
            checkOutput($sformatf("%h c%0d fill_block", base, c), fill_block, expBlk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pipeV[i] = 1'b0;
            pipeA[i] = 16'h0000;
        end
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;

        // Reset held for two cycles, then the first cycle after release.
        applyStimulus();
        #2;
        checkOutput("rst busy", 16'(fsm_busy), 16'h0);
        checkOutput("rst rd_en", 16'(memory_read_en), 16'h0);
        checkOutput("rst rd_addr", memory_address, 16'h0);
        checkOutput("rst wr_tag", 16'(write_tag_array), 16'h0);
        applyStimulus();
        rst = 1'b0;
        #2;
        checkOutput("post-rst busy", 16'(fsm_busy), 16'h0);
        checkOutput("post-rst wr_data", 16'(write_data_array), 16'h0);
        checkOutput("post-rst fill_block", fill_block, 16'h0);
        checkOutput("post-rst fill_word", 16'(fill_word), 16'h0);

        // Spurious data_valid while idle.
        applyStimulus();
        memory_data_valid = 1'b1;
        memory_data       = 16'h5555;
        #2;
        checkOutput("spur wr_data", 16'(write_data_array), 16'h0);
        checkOutput("spur wr_tag", 16'(write_tag_array), 16'h0);
        checkOutput("spur fill_data", fill_data, 16'h5555);
        applyStimulus();
        #2;
        checkOutput("spur after busy", 16'(fsm_busy), 16'h0);

        // Single miss with a second miss pulsed in cycle 3.
        runFill(16'h1236, 16'h1230, 3);

        // Reset in cycle 7 of a fill aborts it.
        applyStimulus();
        miss_detected = 1'b1;
        miss_address  = 16'h2004;
        #2;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus();
            #2;
        end
        checkOutput("abort c6 busy", 16'(fsm_busy), 16'h1);
        applyStimulus();
        rst = 1'b1;
        #2;
        checkOutput("abort c7 wr_tag", 16'(write_tag_array), 16'h0);
        checkOutput("abort c7 wr_data", 16'(write_data_array), 16'h0);
        applyStimulus();
        rst = 1'b0;
        #2;
        checkOutput("abort c8 busy", 16'(fsm_busy), 16'h0);
        checkOutput("abort c8 rd_en", 16'(memory_read_en), 16'h0);
        checkOutput("abort c8 rd_addr", memory_address, 16'h0);
        checkOutput("abort c8 fill_block", fill_block, 16'h0);
        for (int c = 9; c <= 12; c++) begin
            applyStimulus();
            #2;
            checkOutput($sformatf("abort c%0d wr_data", c), 16'(write_data_array), 16'h0);
            checkOutput($sformatf("abort c%0d wr_tag", c), 16'(write_tag_array), 16'h0);
        end

        // Fresh miss after the abort, then a back-to-back miss at the top of memory.
        runFill(16'h00F2, 16'h00F0, 0);
        runFill(16'hFFF8, 16'hFFF0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
